ad9680_capture_ctrl: RTL and testbench
======================================

# ad9680_capture_ctrl

Capture sequencer between the AD9680 JESD204 ADC core outputs and the DMA write interface, in the `rx_clk` (line-rate/40) domain. It arms on a software start, waits for an immediate, edge or level trigger, discards a programmable number of beats, then forwards exactly a programmed number of beats to the DMA. It reports busy, done and sticky overflow status, and can re-arm automatically for continuous bursts.

## Interface
- `LEN_WIDTH`, 16, width of capture length and beat counter
- `HOLDOFF_WIDTH`, 8, width of post-trigger holdoff counter
- `DATA_WIDTH`, 64, per-channel beat width
- `rx_clk` in 1: sole clock
- `rx_resetn` in 1: reset, synchronous, active-low
- `cfg_len` in LEN_WIDTH: beats to capture minus one
- `cfg_trig_mode` in 2: 0 immediate, 1 `ext_trig` rising edge, 2 `ext_trig` level high, 3 same as 0
- `cfg_holdoff` in HOLDOFF_WIDTH: beats discarded after the trigger
- `cfg_continuous` in 1: re-arm after DONE
- `ctrl_start` in 1: one-cycle pulse, arms a capture
- `ctrl_abort` in 1: one-cycle pulse, returns to IDLE
- `ext_trig` in 1: external trigger, already synchronous to `rx_clk`
- `in_enable_0`, `in_enable_1` in 1: channel enables from the ADC core
- `in_valid_0`, `in_valid_1` in 1: channel valids from the ADC core
- `in_data_0`, `in_data_1` in DATA_WIDTH: channel data from the ADC core
- `out_enable_0`, `out_enable_1` out 1: registered copies of the enables
- `out_valid_0`, `out_valid_1` out 1: gated valids to the DMA
- `out_data_0`, `out_data_1` out DATA_WIDTH: registered data to the DMA
- `dma_dovf` in 1: DMA overflow
- `core_dovf` out 1: overflow passthrough to the ADC core, combinational
- `busy` out 1: state is not IDLE
- `done` out 1: one-cycle pulse on DONE
- `ovf` out 1: sticky overflow
- `beat_count` out LEN_WIDTH: beats forwarded in the current capture

## Operation
- A beat is defined as `in_valid_0 | in_valid_1`.
- `ctrl_start` is honoured only in IDLE:
  - latches all `cfg_*` inputs, clears `ovf` and `beat_count`, then moves to ARMED.
  - It is ignored in any other state.
- ARMED:
  - Moves when the trigger condition holds in that cycle.
  - Mode 1 uses `ext_trig & ~ext_trig_q`; `ext_trig_q` is reset to 1 so a trigger that is high out of reset does not fire.
  - Goes to HOLDOFF if the latched holdoff is nonzero, else to CAPTURE.
- HOLDOFF:
  - The counter loads the holdoff value on entry and decrements per beat.
  - A beat seen when the counter is 1 moves the state to CAPTURE.
  - Holdoff beats are never forwarded.
- CAPTURE:
  - Each beat is forwarded and increments `beat_count`.
  - The beat seen when `beat_count == len` is forwarded, and the state moves to DONE.
- DONE lasts one cycle with `done` = 1. The next state is ARMED if `cfg_continuous` was latched, else IDLE.
  - On re-arm, `beat_count` clears and `ovf` is kept.
- Abort and overflow:
  - `ctrl_abort` moves any state to IDLE in the next cycle; beats seen in the abort cycle are not forwarded.
  - When abort and start arrive in the same cycle, abort wins.
  - `dma_dovf` during CAPTURE sets `ovf`. The capture continues.
- Output gating:
  - `out_valid_x` is the registered value of `in_valid_x & in_enable_x & forward`, where `forward` means state is CAPTURE and there is no abort.
  - Data and enables are registered unconditionally.

## Timing
- Reset values:
  - State is IDLE.
  - `out_valid_*`, `out_enable_*`, `done`, `busy`, `ovf` and `beat_count` are 0.
  - `out_data_*` is 0.
- Data path latency is 1 cycle, `in_*` to `out_*`.
- `done`, `busy` and `beat_count` are registered state outputs.
- With mode 0 and holdoff 0:
  - Start is seen at cycle t. ARMED holds at t+1, and CAPTURE at t+2.
  - The first beat eligible for forwarding is at t+2; its `out_valid` appears at t+3.
- With `cfg_len` = N-1, exactly N beats are forwarded, never N+1, regardless of back-to-back valids.
- `beat_count` wraps only at 2^LEN_WIDTH-1 = len; there is no other wrap.
- A mid-operation `rx_resetn` low, sampled on the edge, forces all reset values on the next cycle.

## Structure
- A shared package `ad9680_capture_pkg` holds:
  - the state encodings (IDLE, ARMED, HOLDOFF, CAPTURE, DONE)
  - the trigger-mode constants
- Sub-module `ad9680_trig_detect` holds the `ext_trig_q` register and the mode decode, and outputs `trig_hit`.
- The FSM, counters and output registers form the top level.

## Test plan
- Mode 0, holdoff 0, len 7, continuous valids -> exactly 8 `out_valid` pulses starting at t+3, `done` once, `busy` falls after DONE.
- Mode 1, holdoff 3, `ext_trig` rises at cycle 20 -> the first 3 beats from cycle 21 are dropped, the next `len`+1 beats are forwarded.
- Mode 2 with `ext_trig` low -> stays ARMED indefinitely, no `out_valid`; raising the level starts the capture next cycle.
- `ctrl_abort` mid-CAPTURE at beat 4 of 16 -> IDLE next cycle, no further `out_valid`, no `done`, `beat_count` = 4.
- Continuous, len 3, with `dma_dovf` pulsed in burst 1 -> `ovf` = 1 persists across bursts, `done` pulses every burst, `ovf` clears on the next `ctrl_start` from IDLE.
- `in_enable_1` = 0 -> `out_valid_1` is never asserted, `out_valid_0` behaves normally; start and abort in the same cycle -> stays IDLE.

Source files
------------

// File: rtl/ad9680_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad9680_capture_pkg
//  Description : Shared constants for the AD9680 capture sequencer:
//                FSM state encodings and trigger-mode codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package ad9680_capture_pkg;

    // Sequencer states
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_armed   = 3'd1;
    localparam logic [2:0] c_st_holdoff = 3'd2;
    localparam logic [2:0] c_st_capture = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    // Trigger modes (code 3 behaves like immediate)
    localparam logic [1:0] c_trig_immediate = 2'd0;
    localparam logic [1:0] c_trig_edge      = 2'd1;
    localparam logic [1:0] c_trig_level     = 2'd2;
    localparam logic [1:0] c_trig_imm_alt   = 2'd3;

endpackage : ad9680_capture_pkg
`default_nettype wire

// File: rtl/ad9680_trig_detect.sv
`default_nettype none
// ============================================================================
//  Module      : ad9680_trig_detect
//  Description : Trigger decode for the capture sequencer. Keeps a one-cycle
//                delayed copy of ext_trig for rising-edge detection and
//                decodes the latched trigger mode into a single trig_hit.
//  Ports       : rx_clk, rx_resetn   - clock, sync active-low reset
//                ext_trig            - external trigger (rx_clk domain)
//                trig_mode           - latched trigger mode
//                trig_hit            - trigger condition true this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module ad9680_trig_detect
    import ad9680_capture_pkg::*;
(
    input  logic       rx_clk,
    input  logic       rx_resetn,
    input  logic       ext_trig,
    input  logic [1:0] trig_mode,
    output logic       trig_hit
);

    logic r_ext_trig_q;

    // Resets high so a trigger already asserted out of reset is not an edge.
    always_ff @(posedge rx_clk) begin
        if (!rx_resetn) begin
            r_ext_trig_q <= 1'b1;
        end else begin
            r_ext_trig_q <= ext_trig;
        end
    end

    always_comb begin
        trig_hit = 1'b1;
        case (trig_mode)
            c_trig_edge:  trig_hit = ext_trig & ~r_ext_trig_q;
            c_trig_level: trig_hit = ext_trig;
            default:      trig_hit = 1'b1;
        endcase
    end

endmodule : ad9680_trig_detect
`default_nettype wire

// File: rtl/ad9680_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ad9680_capture_ctrl
//  Description : Capture sequencer between the AD9680 JESD204 ADC core and
//                the DMA write port. Arms on ctrl_start, waits for a trigger,
//                drops cfg_holdoff beats, then forwards cfg_len+1 beats.
//  Ports       : rx_clk, rx_resetn         - clock, sync active-low reset
//                cfg_*                     - capture configuration
//                ctrl_start / ctrl_abort   - one-cycle control pulses
//                ext_trig                  - external trigger
//                in_* / out_*              - ADC core in, DMA out (2 channels)
//                dma_dovf / core_dovf      - overflow in / passthrough
//                busy, done, ovf           - status
//                beat_count                - beats forwarded this capture
//  Revision    : 1.0 - initial release
// ============================================================================
module ad9680_capture_ctrl
    import ad9680_capture_pkg::*;
#(
    parameter int LEN_WIDTH     = 16,
    parameter int HOLDOFF_WIDTH = 8,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                     rx_clk,
    input  logic                     rx_resetn,
    input  logic [LEN_WIDTH-1:0]     cfg_len,
    input  logic [1:0]               cfg_trig_mode,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
    input  logic                     cfg_continuous,
    input  logic                     ctrl_start,
    input  logic                     ctrl_abort,
    input  logic                     ext_trig,
    input  logic                     in_enable_0,
    input  logic                     in_enable_1,
    input  logic                     in_valid_0,
    input  logic                     in_valid_1,
    input  logic [DATA_WIDTH-1:0]    in_data_0,
    input  logic [DATA_WIDTH-1:0]    in_data_1,
    output logic                     out_enable_0,
    output logic                     out_enable_1,
    output logic                     out_valid_0,
    output logic                     out_valid_1,
    output logic [DATA_WIDTH-1:0]    out_data_0,
    output logic [DATA_WIDTH-1:0]    out_data_1,
    input  logic                     dma_dovf,
    output logic                     core_dovf,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf,
    output logic [LEN_WIDTH-1:0]     beat_count
);

    // Latched configuration
    logic [LEN_WIDTH-1:0]     r_len;
    logic [1:0]               r_mode;
    logic [HOLDOFF_WIDTH-1:0] r_holdoff;
    logic                     r_cont;

    logic [2:0]               r_state;
    logic [2:0]               w_state_nxt;
    logic [HOLDOFF_WIDTH-1:0] r_hold_cnt;
    logic [LEN_WIDTH-1:0]     r_beat_count;
    logic                     r_ovf;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_beat;
    logic                     w_forward;
    logic                     w_trig_hit;

    assign w_beat    = in_valid_0 | in_valid_1;
    assign w_forward = (r_state == c_st_capture) & ~ctrl_abort;

    assign core_dovf  = dma_dovf;
    assign busy       = r_busy;
    assign done       = r_done;
    assign ovf        = r_ovf;
    assign beat_count = r_beat_count;

    ad9680_trig_detect u_trig_detect (
        .rx_clk    (rx_clk),
        .rx_resetn (rx_resetn),
        .ext_trig  (ext_trig),
        .trig_mode (r_mode),
        .trig_hit  (w_trig_hit)
    );

    // Next-state decode; abort overrides every transition including start.
    always_comb begin
        w_state_nxt = r_state;
        if (ctrl_abort) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (ctrl_start) w_state_nxt = c_st_armed;
                end
                c_st_armed: begin
                    if (w_trig_hit) begin
                        w_state_nxt = (r_holdoff != '0) ? c_st_holdoff : c_st_capture;
                    end
                end
                c_st_holdoff: begin
                    if (w_beat && (r_hold_cnt == HOLDOFF_WIDTH'(1))) w_state_nxt = c_st_capture;
                end
                c_st_capture: begin
                    if (w_beat && (r_beat_count == r_len)) w_state_nxt = c_st_done;
                end
                c_st_done: begin
                    w_state_nxt = r_cont ? c_st_armed : c_st_idle;
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!rx_resetn) begin
            r_state      <= c_st_idle;
            r_len        <= '0;
            r_mode       <= c_trig_immediate;
            r_holdoff    <= '0;
            r_cont       <= 1'b0;
            r_hold_cnt   <= '0;
            r_beat_count <= '0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            out_enable_0 <= 1'b0;
            out_enable_1 <= 1'b0;
            out_valid_0  <= 1'b0;
            out_valid_1  <= 1'b0;
            out_data_0   <= '0;
            out_data_1   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_st_idle);
            r_done  <= (w_state_nxt == c_st_done);

            out_enable_0 <= in_enable_0;
            out_enable_1 <= in_enable_1;
            out_valid_0  <= in_valid_0 & in_enable_0 & w_forward;
            out_valid_1  <= in_valid_1 & in_enable_1 & w_forward;
            out_data_0   <= in_data_0;
            out_data_1   <= in_data_1;

            // Overflow is observed even in an abort cycle; the capture itself
            // is not stopped by it.
            if ((r_state == c_st_capture) && dma_dovf) r_ovf <= 1'b1;

            if (!ctrl_abort) begin
                case (r_state)
                    c_st_idle: begin
                        if (ctrl_start) begin
                            r_len        <= cfg_len;
                            r_mode       <= cfg_trig_mode;
                            r_holdoff    <= cfg_holdoff;
                            r_cont       <= cfg_continuous;
                            r_ovf        <= 1'b0;
                            r_beat_count <= '0;
                        end
                    end
                    c_st_armed: begin
                        if (w_trig_hit) r_hold_cnt <= r_holdoff;
                    end
                    c_st_holdoff: begin
                        if (w_beat) r_hold_cnt <= r_hold_cnt - HOLDOFF_WIDTH'(1);
                    end
                    c_st_capture: begin
                        if (w_beat) r_beat_count <= r_beat_count + LEN_WIDTH'(1);
                    end
                    c_st_done: begin
                        // Re-arm starts a fresh count but keeps sticky overflow.
                        if (r_cont) r_beat_count <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule : ad9680_capture_ctrl
`default_nettype wire

// File: tb/tb_ad9680_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad9680_capture_ctrl
//  Description : Directed self-checking bench for ad9680_capture_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad9680_capture_ctrl;

    logic        clk = 1'b0;
    logic        rx_resetn;
    logic [15:0] cfg_len;
    logic [1:0]  cfg_trig_mode;
    logic [7:0]  cfg_holdoff;
    logic        cfg_continuous;
    logic        ctrl_start, ctrl_abort, ext_trig;
    logic        in_enable_0, in_enable_1, in_valid_0, in_valid_1;
    logic [63:0] in_data_0, in_data_1;
    logic        out_enable_0, out_enable_1, out_valid_0, out_valid_1;
    logic [63:0] out_data_0, out_data_1;
    logic        dma_dovf, core_dovf, busy, done, ovf;
    logic [15:0] beat_count;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ad9680_capture_ctrl #(
        .LEN_WIDTH(16), .HOLDOFF_WIDTH(8), .DATA_WIDTH(64)
    ) dut (
        .rx_clk(clk), .rx_resetn(rx_resetn),
        .cfg_len(cfg_len), .cfg_trig_mode(cfg_trig_mode),
        .cfg_holdoff(cfg_holdoff), .cfg_continuous(cfg_continuous),
        .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort), .ext_trig(ext_trig),
        .in_enable_0(in_enable_0), .in_enable_1(in_enable_1),
        .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
        .in_data_0(in_data_0), .in_data_1(in_data_1),
        .out_enable_0(out_enable_0), .out_enable_1(out_enable_1),
        .out_valid_0(out_valid_0), .out_valid_1(out_valid_1),
        .out_data_0(out_data_0), .out_data_1(out_data_1),
        .dma_dovf(dma_dovf), .core_dovf(core_dovf),
        .busy(busy), .done(done), .ovf(ovf), .beat_count(beat_count)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [15:0] len, input logic [1:0] mode,
                       input logic [7:0] hold, input logic cont);
        cfg_len = len; cfg_trig_mode = mode; cfg_holdoff = hold; cfg_continuous = cont;
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
    endtask

    task automatic test_reset();
        rx_resetn = 1'b0;
        ext_trig = 1'b1;
        in_enable_0 = 1'b1; in_enable_1 = 1'b1;
        in_valid_0 = 1'b1; in_valid_1 = 1'b1;
        in_data_0 = 64'hDEAD_BEEF_0000_0001; in_data_1 = 64'h1234;
        repeat (3) step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        vectors++; if (beat_count !== 16'd0) begin miscompares++; $display("FAIL rst_beat_count: got %0d want 0", beat_count); end
        vectors++; if ({out_valid_0, out_valid_1, out_enable_0, out_enable_1} !== 4'b0000) begin
            miscompares++; $display("FAIL rst_out_flags: got %b want 0000", {out_valid_0, out_valid_1, out_enable_0, out_enable_1}); end
        vectors++; if (out_data_0 !== 64'd0) begin miscompares++; $display("FAIL rst_out_data_0: got %h want 0", out_data_0); end
        rx_resetn = 1'b1;
    endtask

    // ext_trig held high through reset must not look like a rising edge.
    task automatic test_trig_high_after_reset();
        int cnt = 0;
        arm(16'd3, 2'd1, 8'd0, 1'b0);
        repeat (8) begin step(); if (out_valid_0) cnt++; end
        vectors++; if (cnt != 0) begin miscompares++; $display("FAIL trig_high_no_fire: got %0d pulses want 0", cnt); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL trig_high_armed: got busy %b want 1", busy); end
        ctrl_abort = 1'b1; step(); ctrl_abort = 1'b0;
        ext_trig = 1'b0; step();
    endtask

    task automatic test_immediate();
        int cnt = 0, dcnt = 0, first = -1, last = -1;
        arm(16'd7, 2'd0, 8'd0, 1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL imm_busy_t1: got %b want 1", busy); end
        vectors++; if (out_valid_0 !== 1'b0) begin miscompares++; $display("FAIL imm_valid_t1: got %b want 0", out_valid_0); end
        step();
        vectors++; if (out_valid_0 !== 1'b0) begin miscompares++; $display("FAIL imm_valid_t2: got %b want 0", out_valid_0); end
        for (int i = 0; i < 20; i++) begin
            in_data_0 = 64'hA000 + 64'(i);
            step();
            if (done) dcnt++;
            if (out_valid_0) begin
                if (first < 0) begin
                    first = i;
                    vectors++; if (out_data_0 !== 64'hA000) begin miscompares++; $display("FAIL imm_first_data: got %h want a000", out_data_0); end
                end
                last = i; cnt++;
            end
        end
        vectors++; if (cnt != 8) begin miscompares++; $display("FAIL imm_pulses: got %0d want 8", cnt); end
        vectors++; if (first != 0) begin miscompares++; $display("FAIL imm_first_idx: got %0d want 0", first); end
        vectors++; if (last != 7) begin miscompares++; $display("FAIL imm_last_idx: got %0d want 7", last); end
        vectors++; if (dcnt != 1) begin miscompares++; $display("FAIL imm_done_count: got %0d want 1", dcnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL imm_busy_end: got %b want 0", busy); end
        vectors++; if (beat_count !== 16'd8) begin miscompares++; $display("FAIL imm_beat_count: got %0d want 8", beat_count); end
    endtask

    task automatic test_edge_holdoff();
        int cnt = 0, dcnt = 0, first = -1;
        ext_trig = 1'b0;
        arm(16'd3, 2'd1, 8'd3, 1'b0);
        repeat (3) begin step(); if (out_valid_0) cnt++; end
        vectors++; if (cnt != 0) begin miscompares++; $display("FAIL edge_armed_quiet: got %0d pulses want 0", cnt); end
        for (int i = 0; i < 16; i++) begin
            ext_trig = 1'b1;
            in_data_0 = 64'hB000 + 64'(i);
            step();
            if (done) dcnt++;
            if (out_valid_0) begin
                if (first < 0) begin
                    first = i;
                    vectors++; if (out_data_0 !== 64'hB004) begin miscompares++; $display("FAIL edge_first_data: got %h want b004", out_data_0); end
                end
                cnt++;
            end
        end
        ext_trig = 1'b0;
        vectors++; if (first != 4) begin miscompares++; $display("FAIL edge_first_idx: got %0d want 4", first); end
        vectors++; if (cnt != 4) begin miscompares++; $display("FAIL edge_pulses: got %0d want 4", cnt); end
        vectors++; if (dcnt != 1) begin miscompares++; $display("FAIL edge_done_count: got %0d want 1", dcnt); end
    endtask

    task automatic test_level();
        int cnt = 0, first = -1;
        ext_trig = 1'b0;
        arm(16'd1, 2'd2, 8'd0, 1'b0);
        repeat (10) begin step(); if (out_valid_0) cnt++; end
        vectors++; if (cnt != 0) begin miscompares++; $display("FAIL level_low_quiet: got %0d pulses want 0", cnt); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL level_armed: got busy %b want 1", busy); end
        for (int i = 0; i < 8; i++) begin
            ext_trig = 1'b1;
            step();
            if (out_valid_0) begin if (first < 0) first = i; cnt++; end
        end
        ext_trig = 1'b0;
        vectors++; if (first != 1) begin miscompares++; $display("FAIL level_first_idx: got %0d want 1", first); end
        vectors++; if (cnt != 2) begin miscompares++; $display("FAIL level_pulses: got %0d want 2", cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL level_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_abort();
        int cnt = 0, dcnt = 0;
        arm(16'd15, 2'd0, 8'd0, 1'b0);
        step();
        repeat (4) begin step(); if (out_valid_0) cnt++; end
        vectors++; if (cnt != 4) begin miscompares++; $display("FAIL abort_pre_pulses: got %0d want 4", cnt); end
        ctrl_abort = 1'b1; step(); ctrl_abort = 1'b0;
        vectors++; if (out_valid_0 !== 1'b0) begin miscompares++; $display("FAIL abort_cycle_valid: got %b want 0", out_valid_0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
        vectors++; if (beat_count !== 16'd4) begin miscompares++; $display("FAIL abort_beat_count: got %0d want 4", beat_count); end
        cnt = 0;
        repeat (6) begin step(); if (out_valid_0) cnt++; if (done) dcnt++; end
        vectors++; if (cnt != 0 || dcnt != 0) begin miscompares++; $display("FAIL abort_after: got %0d pulses %0d dones want 0 0", cnt, dcnt); end
    endtask

    task automatic test_continuous_ovf();
        int cnt = 0, dcnt = 0;
        arm(16'd3, 2'd0, 8'd0, 1'b1);
        for (int j = 0; j < 24; j++) begin
            if (j == 2) begin
                dma_dovf = 1'b1;
                #1;
                vectors++; if (core_dovf !== 1'b1) begin miscompares++; $display("FAIL cont_core_dovf: got %b want 1", core_dovf); end
                vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL cont_ovf_before: got %b want 0", ovf); end
            end else begin
                dma_dovf = 1'b0;
            end
            step();
            if (out_valid_0) cnt++;
            if (done) dcnt++;
        end
        dma_dovf = 1'b0;
        vectors++; if (dcnt != 4) begin miscompares++; $display("FAIL cont_done_count: got %0d want 4", dcnt); end
        vectors++; if (cnt != 16) begin miscompares++; $display("FAIL cont_pulses: got %0d want 16", cnt); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL cont_ovf_sticky: got %b want 1", ovf); end
        ctrl_abort = 1'b1; step(); ctrl_abort = 1'b0;
        vectors++; if (ovf !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL cont_abort_state: got ovf %b busy %b want 1 0", ovf, busy); end
        arm(16'd3, 2'd0, 8'd0, 1'b0);
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL cont_ovf_clear: got %b want 0", ovf); end
        vectors++; if (beat_count !== 16'd0) begin miscompares++; $display("FAIL cont_count_clear: got %0d want 0", beat_count); end
        ctrl_abort = 1'b1; step(); ctrl_abort = 1'b0;
    endtask

    task automatic test_enable_and_start_abort();
        int c0 = 0, c1 = 0;
        in_enable_1 = 1'b0;
        arm(16'd2, 2'd0, 8'd0, 1'b0);
        repeat (10) begin step(); if (out_valid_0) c0++; if (out_valid_1) c1++; end
        vectors++; if (c0 != 3) begin miscompares++; $display("FAIL en_valid0_pulses: got %0d want 3", c0); end
        vectors++; if (c1 != 0) begin miscompares++; $display("FAIL en_valid1_pulses: got %0d want 0", c1); end
        vectors++; if ({out_enable_0, out_enable_1} !== 2'b10) begin miscompares++; $display("FAIL en_out_enables: got %b want 10", {out_enable_0, out_enable_1}); end
        in_enable_1 = 1'b1;
        ctrl_start = 1'b1; ctrl_abort = 1'b1; step(); ctrl_start = 1'b0; ctrl_abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sa_busy_1: got %b want 0", busy); end
        repeat (3) step();
        vectors++; if (busy !== 1'b0 || out_valid_0 !== 1'b0) begin miscompares++; $display("FAIL sa_idle: got busy %b valid %b want 0 0", busy, out_valid_0); end
    endtask

    task automatic test_mid_reset();
        arm(16'd15, 2'd0, 8'd0, 1'b0);
        repeat (4) step();
        rx_resetn = 1'b0; step();
        vectors++; if ({busy, out_valid_0, out_enable_0} !== 3'b000) begin miscompares++; $display("FAIL mrst_flags: got %b want 000", {busy, out_valid_0, out_enable_0}); end
        vectors++; if (beat_count !== 16'd0) begin miscompares++; $display("FAIL mrst_beat_count: got %0d want 0", beat_count); end
        vectors++; if (out_data_0 !== 64'd0) begin miscompares++; $display("FAIL mrst_out_data: got %h want 0", out_data_0); end
        rx_resetn = 1'b1; step();
    endtask

    initial begin
        cfg_len = '0; cfg_trig_mode = '0; cfg_holdoff = '0; cfg_continuous = 1'b0;
        ctrl_start = 1'b0; ctrl_abort = 1'b0; dma_dovf = 1'b0;
        test_reset();
        test_trig_high_after_reset();
        test_immediate();
        test_edge_holdoff();
        test_level();
        test_abort();
        test_continuous_ovf();
        test_enable_and_start_abort();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ad9680_capture_ctrl
`default_nettype wire
